// File: rtl/alu_share_arb_pkg.sv
// Shared constants and types for the two-port ALU share arbiter.
// Opcode codes match the shared ALU; port indices name the two requesters.
package alu_share_arb_pkg;
   localparam int XLEN      = 32;
   localparam int OP_W      = 4;
   localparam int NUM_PORTS = 2;

   localparam int PORT_EXE = 0;
   localparam int PORT_AGU = 1;

   localparam logic [OP_W-1:0] ALU_ADD   = 4'd0;
   localparam logic [OP_W-1:0] ALU_SUB   = 4'd1;
   localparam logic [OP_W-1:0] ALU_AND   = 4'd2;
   localparam logic [OP_W-1:0] ALU_OR    = 4'd3;
   localparam logic [OP_W-1:0] ALU_XOR   = 4'd4;
   localparam logic [OP_W-1:0] ALU_SLT   = 4'd5;
   localparam logic [OP_W-1:0] ALU_SLL   = 4'd6;
   localparam logic [OP_W-1:0] ALU_SLTU  = 4'd7;
   localparam logic [OP_W-1:0] ALU_SRL   = 4'd8;
   localparam logic [OP_W-1:0] ALU_SRA   = 4'd9;
   localparam logic [OP_W-1:0] ALU_COPY1 = 4'd10;
   localparam logic [OP_W-1:0] ALU_COPY2 = 4'd11;

   typedef struct packed {
      logic [XLEN-1:0] in1;
      logic [XLEN-1:0] in2;
      logic [OP_W-1:0] op;
   } alu_req_t;
endpackage

// File: rtl/alu_share_arb_if.sv
// Request/response bundle between the two ALU requesters and the arbiter.
// Per-port vectors are packed [port][bit], so port i sits at [i*W +: W].
interface alu_share_arb_if;
   import alu_share_arb_pkg::*;

   logic [NUM_PORTS-1:0]           req_valid;
   logic [NUM_PORTS-1:0]           req_ready;
   logic [NUM_PORTS-1:0][XLEN-1:0] req_in1;
   logic [NUM_PORTS-1:0][XLEN-1:0] req_in2;
   logic [NUM_PORTS-1:0][OP_W-1:0] req_op;
   logic [NUM_PORTS-1:0]           rsp_valid;
   logic [NUM_PORTS-1:0]           rsp_ready;
   logic [XLEN-1:0]                rsp_data;

   modport master (
      output req_valid, req_in1, req_in2, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_data
   );
   modport slave (
      input  req_valid, req_in1, req_in2, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_data
   );
endinterface

// File: rtl/alu_share_rr_pick.sv
// Two-way grant picker. ALU_SHARE_ARB_RR_EN selects round-robin on conflict;
// without it port 0 always wins and last_gnt is ignored.
module alu_share_rr_pick (
   input  logic [1:0] req_valid,
   input  logic       last_gnt,
   input  logic       enable,
   output logic [1:0] gnt
);
`ifndef ALU_SHARE_ARB_RR_EN
   logic unused_last_gnt;
   assign unused_last_gnt = last_gnt;
`endif

   always_comb begin
      gnt = 2'b00;
      if (enable) begin
`ifdef ALU_SHARE_ARB_RR_EN
         // on conflict the port that did not win last time goes next
         if (req_valid == 2'b11) gnt = last_gnt ? 2'b01 : 2'b10;
         else                    gnt = req_valid;
`else
         if (req_valid[0])      gnt = 2'b01;
         else if (req_valid[1]) gnt = 2'b10;
`endif
      end
   end
endmodule

// File: rtl/alu_share_arb.sv
// Time-shares one external combinational ALU between two requesters and holds
// the result in a one-entry response register. Macro: ALU_SHARE_ARB_RR_EN.
module alu_share_arb
   import alu_share_arb_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   alu_share_arb_if.slave   bus,
   output logic [XLEN-1:0]  alu_in1,
   output logic [XLEN-1:0]  alu_in2,
   output logic [OP_W-1:0]  alu_op,
   input  logic [XLEN-1:0]  alu_out
);
   localparam logic [0:0] ST_EMPTY = 1'b0;
   localparam logic [0:0] ST_FULL  = 1'b1;

   logic [0:0]                state;
   logic                      rsp_full;
   logic                      rsp_owner;
   logic [XLEN-1:0]           rsp_q;
   logic                      last_gnt;
   logic                      drain;
   logic                      can_accept;
   logic                      any_gnt;
   logic                      gnt_idx;
   logic [NUM_PORTS-1:0]      gnt;
   alu_req_t [NUM_PORTS-1:0]  port_req;
   alu_req_t                  sel_req;

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
      assign port_req[i] = '{in1: bus.req_in1[i], in2: bus.req_in2[i], op: bus.req_op[i]};
      assign bus.rsp_valid[i] = rsp_full && (rsp_owner == 1'(i));
   end

   assign rsp_full   = (state == ST_FULL);
   assign drain      = rsp_full && bus.rsp_ready[rsp_owner];
   assign can_accept = !rsp_full || drain;

   // reset also gates the picker so req_ready is low for the whole reset
   alu_share_rr_pick u_pick (
      .req_valid (bus.req_valid),
      .last_gnt  (last_gnt),
      .enable    (can_accept && rst_n),
      .gnt       (gnt)
   );

   assign any_gnt       = |gnt;
   assign gnt_idx       = gnt[1];
   assign bus.req_ready = gnt;
   assign bus.rsp_data  = rsp_q;

   // no grant leaves gnt_idx at 0, so the ALU sees port 0 and the result is dropped
   assign sel_req = port_req[gnt_idx];
   assign alu_in1 = sel_req.in1;
   assign alu_in2 = sel_req.in2;
   assign alu_op  = sel_req.op;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= ST_EMPTY;
         rsp_owner <= 1'b0;
         rsp_q     <= '0;
      end else if (any_gnt) begin
         state     <= ST_FULL;
         rsp_owner <= gnt_idx;
         rsp_q     <= alu_out;
      end else if (drain) begin
         state     <= ST_EMPTY;
      end
   end

`ifdef ALU_SHARE_ARB_RR_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)       last_gnt <= 1'b1;
      else if (any_gnt) last_gnt <= gnt_idx;
   end
`else
   assign last_gnt = 1'b1;
`endif
endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios plus random traffic
// against a queue-based reference model and a behavioural ALU.
module tb_alu_share_arb;
   import alu_share_arb_pkg::*;

   logic            clk = 1'b0;
   logic            rst_n;
   logic [XLEN-1:0] alu_in1, alu_in2, alu_out;
   logic [OP_W-1:0] alu_op;

   alu_share_arb_if bus ();

   alu_share_arb dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .bus     (bus),
      .alu_in1 (alu_in1),
      .alu_in2 (alu_in2),
      .alu_op  (alu_op),
      .alu_out (alu_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] ref_alu(input logic [31:0] a, input logic [31:0] b,
                                           input logic [3:0] op);
      case (op)
         ALU_ADD:   return a + b;
         ALU_SUB:   return a - b;
         ALU_AND:   return a & b;
         ALU_OR:    return a | b;
         ALU_XOR:   return a ^ b;
         ALU_SLT:   return {31'd0, $signed(a) < $signed(b)};
         ALU_SLL:   return a << b[4:0];
         ALU_SLTU:  return {31'd0, a < b};
         ALU_SRL:   return a >> b[4:0];
         ALU_SRA:   return $unsigned($signed(a) >>> b[4:0]);
         ALU_COPY1: return a;
         ALU_COPY2: return b;
         default:   return 32'd0;
      endcase
   endfunction

   always_comb alu_out = ref_alu(alu_in1, alu_in2, alu_op);

   typedef struct {
      logic        port;
      logic [31:0] data;
   } exp_t;

   exp_t        mq[$];
   logic        prefer;
   logic [1:0][31:0] p_in1, p_in2;
   logic [1:0][3:0]  p_op;
   logic [1:0]  acc;
   logic [1:0]  obs_ready;
   int          n_chk = 0;
   int          n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic set_port(input int p, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
      p_op[p] = op; p_in1[p] = a; p_in2[p] = b;
   endtask

   // one clock: drive at negedge, compare after settle, advance model at posedge
   task automatic cycle(input logic [1:0] v, input logic [1:0] rr);
      logic [1:0] e_vld, e_rdy;
      logic       win, can;
      bus.req_valid = v;
      bus.rsp_ready = rr;
      bus.req_in1   = p_in1;
      bus.req_in2   = p_in2;
      bus.req_op    = p_op;
      #1;
      e_vld = 2'b00;
      can   = 1'b1;
      if (mq.size() != 0) begin
         e_vld[mq[0].port] = 1'b1;
         can = rr[mq[0].port];
         chk("rsp_data", bus.rsp_data, mq[0].data);
      end
      chk("rsp_valid", 32'(bus.rsp_valid), 32'(e_vld));
      win   = (v == 2'b11) ? prefer : v[1];
      e_rdy = 2'b00;
      if (can && v != 2'b00) e_rdy[win] = 1'b1;
      obs_ready = bus.req_ready;
      acc = e_rdy;
      chk("req_ready", 32'(bus.req_ready), 32'(e_rdy));
      @(posedge clk);
      if (mq.size() != 0 && rr[mq[0].port]) void'(mq.pop_front());
      if (e_rdy != 2'b00) begin
         mq.push_back('{port: win, data: ref_alu(p_in1[win], p_in2[win], p_op[win])});
`ifdef ALU_SHARE_ARB_RR_EN
         prefer = ~win;
`endif
      end
      @(negedge clk);
   endtask

   initial begin
      int cnt;
      logic [1:0] v, rr, pend;
      rst_n = 1'b0;
      prefer = 1'b0;
      p_in1 = '0; p_in2 = '0; p_op = '0;
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b11;
      bus.req_in1 = '0; bus.req_in2 = '0; bus.req_op = '0;
      repeat (2) @(negedge clk);
      #1;
      chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_data", bus.rsp_data, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // both ports contend every cycle
      set_port(0, ALU_SUB, 32'd10, 32'd3);
      set_port(1, ALU_XOR, 32'hFF, 32'h0F);
      for (int k = 0; k < 4; k++) begin
         cycle(2'b11, 2'b11);
`ifdef ALU_SHARE_ARB_RR_EN
         chk("alt_gnt", 32'(obs_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
         chk("alt_data", bus.rsp_data, (k % 2 == 0) ? 32'h7 : 32'hF0);
`else
         chk("fix_gnt", 32'(obs_ready), 32'd1);
         chk("fix_data", bus.rsp_data, 32'h7);
`endif
      end
      cycle(2'b00, 2'b11);

      // single ADD on port 0
      set_port(0, ALU_ADD, 32'd5, 32'd7);
      cycle(2'b01, 2'b11);
      chk("add_ready", 32'(obs_ready), 32'd1);
      chk("add_valid", 32'(bus.rsp_valid), 32'd1);
      chk("add_data", bus.rsp_data, 32'd12);
      cycle(2'b00, 2'b11);

      // owner stall on port 1 blocks everything
      set_port(1, ALU_SRA, 32'h8000_0000, 32'd4);
      cycle(2'b10, 2'b11);
      for (int k = 0; k < 3; k++) begin
         cycle(2'b11, 2'b01);
         chk("stall_ready", 32'(obs_ready), 32'd0);
         chk("stall_data", bus.rsp_data, 32'hF800_0000);
      end
      cycle(2'b11, 2'b11);
      chk("stall_resume", 32'(obs_ready != 2'b00), 32'd1);
      cycle(2'b00, 2'b11);
      cycle(2'b00, 2'b11);

      // back-to-back stream on port 0
      cnt = 0;
      for (int k = 0; k < 4; k++) begin
         set_port(0, ALU_ADD, 32'(k), 32'd100);
         cycle(2'b01, 2'b11);
         if (bus.rsp_valid == 2'b01) cnt++;
      end
      chk("b2b_cnt", 32'(cnt), 32'd4);
      chk("b2b_last", bus.rsp_data, 32'd103);
      cycle(2'b00, 2'b11);

      // reset while a result is held
      set_port(0, ALU_OR, 32'hA0, 32'h0B);
      cycle(2'b01, 2'b00);
      bus.req_valid = 2'b11;
      bus.rsp_ready = 2'b00;
      rst_n = 1'b0;
      #1;
      chk("midrst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("midrst_req_ready", 32'(bus.req_ready), 32'd0);
      chk("midrst_rsp_data", bus.rsp_data, 32'd0);
      mq.delete();
      prefer = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      cycle(2'b11, 2'b11);
      chk("postrst_gnt", 32'(obs_ready), 32'd1);
      cycle(2'b00, 2'b11);

      // random traffic; a waiting request keeps its payload
      pend = 2'b00;
      v = 2'b00;
      for (int c = 0; c < 400; c++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend[p]) begin
               v[p] = ($urandom_range(0, 2) != 0);
               set_port(p, 4'($urandom_range(0, 11)), $urandom, $urandom);
            end
            rr[p] = ($urandom_range(0, 3) != 0);
         end
         cycle(v, rr);
         pend = v & ~acc;
      end

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter and result buffer that time-shares one ALU between two requesters, e.g. the execute stage (port 0) and a branch/address unit (port 1). Requests use valid/ready handshakes. The block drives the ALU operand and opcode lines from the granted port, captures the combinational ALU result in a one-entry response register, and returns it on the owning port's response channel. One operation can complete per cycle.

## Interface
- XLEN, 32, operand/result width
- OP_W, 4, ALU opcode width (codes from the shared ALU opcode package)
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  2  per-port request valid
- req_ready  out  2  per-port request accepted this cycle
- req_in1  in  2*XLEN  per-port operand 1; port i occupies bits [i*XLEN +: XLEN]
- req_in2  in  2*XLEN  per-port operand 2 (rs2 or immediate)
- req_op  in  2*OP_W  per-port ALU opcode
- rsp_valid  out  2  per-port result valid
- rsp_ready  in  2  per-port result consumed
- rsp_data  out  XLEN  result; shared by both ports, qualified by rsp_valid
- alu_in1  out  XLEN  to the ALU
- alu_in2  out  XLEN  to the ALU
- alu_op  out  OP_W  to the ALU
- alu_out  in  XLEN  combinational ALU result

## Operation
- **State.**
  - rsp_full: response register occupied.
  - rsp_owner: port that owns the held result.
  - rsp_q: held result.
  - last_gnt: port granted most recently.
- **Response register FSM, two states.**
  - EMPTY → FULL on a grant.
  - FULL → EMPTY on drain with no new grant.
  - FULL → FULL on drain plus a simultaneous grant (back-to-back).
- **Drain.** Occurs when rsp_full and rsp_ready[rsp_owner] are both 1.
- **Accept condition.** can_accept = !rsp_full | drain.
- **Grant.**
  - Considered only when can_accept.
  - Exactly one port is granted when any req_valid is high.
  - req_ready[i] = can_accept & gnt[i]. At most one bit is set.
- **Arbitration.** Round-robin: on a conflict, the port other than last_gnt wins. last_gnt updates only on a grant.
- **ALU drive.**
  - alu_in1/alu_in2/alu_op are muxed from the granted port.
  - With no grant they are driven from port 0 and the result is discarded.
- **Capture.** On a grant: rsp_q ← alu_out, rsp_owner ← granted index, rsp_full ← 1.
- **Response outputs.**
  - rsp_valid[i] = rsp_full & (rsp_owner == i).
  - rsp_data = rsp_q.
- **Backpressure.**
  - A stalled owner (rsp_ready low) blocks all new grants.
  - The non-owner's rsp_ready is ignored.
- **Payload stability.** A requester holds req_in1/req_in2/req_op stable while req_valid is high and req_ready is low. The block does not check this.
- **Reset (asynchronous, any cycle).**
  - Values: rsp_full=0, rsp_owner=0, rsp_q=0, last_gnt=1 (port 0 wins the first conflict).
  - Outputs: req_ready=0, rsp_valid=0, rsp_data=0.
  - An in-flight result is dropped. Requesters must reissue.

## Timing
- Request accepted in cycle N → rsp_valid in cycle N+1, with rsp_data equal to the ALU result of the accepted operands.
- Throughput: one result per cycle while the owner holds rsp_ready high.
- req_ready depends combinationally on req_valid and on rsp_ready of the current owner. No combinational path from rsp_ready to rsp_valid.
- Data path: the critical path is req mux → ALU → rsp_q.

## Configuration
- Macro: ALU_SHARE_ARB_RR_EN.
- Defined: round-robin arbitration as described.
- Undefined: fixed priority, port 0 always wins. last_gnt is not implemented. Port 1 can starve under continuous port-0 traffic.

## Structure
- **Shared package:**
  - ALU opcode constants (ADD, SUB, AND, OR, XOR, SLT, SLL, SLTU, SRL, SRA, COPY1, COPY2).
  - XLEN.
  - Port index constants PORT_EXE=0, PORT_AGU=1.
- **Sub-module:** alu_share_rr_pick (combinational two-way round-robin picker). Inputs: req_valid, last_gnt, enable. Output: one-hot grant. Its round-robin path is compiled out without the macro.
- **ALU:** external to this block.

## Test plan
- Port 0 only: ADD in1=5 in2=7 in cycle N → rsp_valid=2'b01, rsp_data=12 in cycle N+1. req_ready[0]=1 in N.
- Both ports valid every cycle, both rsp_ready=1; port 0 SUB 10-3, port 1 XOR FF^0F:
  - RR defined: grants alternate 0,1,0,1, starting with port 0. Results 7 and F0 alternate on rsp_valid 01/10.
  - RR undefined: only port 0 is served.
- Port 1 holds rsp_ready=0 for 3 cycles after an SRA 0x80000000>>4 result:
  - rsp_data is held at 0xF8000000.
  - req_ready=0 on both ports.
  - The grant resumes in the same cycle rsp_ready[1] rises.
- Back-to-back: port 0 streams 4 ops with rsp_ready=1 → 4 consecutive rsp_valid cycles, no bubbles.
- Reset asserted while rsp_full=1 → rsp_valid=0 and req_ready=0 immediately. After release, the first conflict is granted to port 0.
